fifo_stream_unpacker: RTL and testbench
=======================================

Name: fifo_stream_unpacker

Overview:
- Read-side drain stage directly downstream of fifo_sync: pulls pDATA_WIDTH-bit words from the FIFO read port and emits them as pOUT_WIDTH-bit beats on a valid/ready stream, such as a byte stream toward the USB/host read path.
- Each transfer is a burst of a requested number of output beats, started by a single-cycle start pulse.
- Never reads an empty FIFO.
- Supports both FIFO read modes: normal (1-cycle read latency) and first-word-fall-through.

Parameters:
- pDATA_WIDTH, 16, FIFO word width; must be an integer multiple of pOUT_WIDTH, ratio R = pDATA_WIDTH/pOUT_WIDTH >= 2.
- pOUT_WIDTH, 8, output beat width.
- pFWFT, 0, 1 = FIFO is first-word-fall-through (rdata valid while !empty, ren pops); 0 = rdata valid the cycle after ren.
- pMSB_FIRST, 1, 1 = most-significant slice of each word is sent first; 0 = least-significant first.
- pCOUNT_WIDTH, 16, width of the beat-count request.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous reset, active-high.
- start, input, 1, 1-cycle pulse; begins a burst; ignored while busy.
- count, input, pCOUNT_WIDTH, output beats requested; sampled with start.
- abort, input, 1, terminates the current burst.
- busy, output, 1, burst in progress.
- done, output, 1, 1-cycle pulse at burst completion or abort.
- words_read, output, pCOUNT_WIDTH, FIFO pops in the current or last burst.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_ren, output, 1, FIFO read enable.
- fifo_rdata, input, pDATA_WIDTH, FIFO read data.
- dout, output, pOUT_WIDTH, output beat.
- dout_valid, output, 1, dout is valid.
- dout_ready, input, 1, consumer accepts the beat.

Behaviour:
- Reset values: busy=0, done=0, fifo_ren=0, dout_valid=0, dout=0, words_read=0; all internal registers cleared; state IDLE.
- Reset mid-burst: next cycle all outputs are at reset values. No done pulse is issued.
- Words needed: W = ceil(count/R), computed with pCOUNT_WIDTH+1-bit arithmetic (no overflow).
- State machine:
  - IDLE: on start, latch count and clear words_read. If count==0, go to DONE (no FIFO reads); otherwise go to RUN. Set busy=1 from the cycle after start.
  - RUN: fetch words and emit beats (rules below). When the last requested beat is accepted (dout_valid&&dout_ready), go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE. start is not accepted in DONE.
- Fetch rules:
  - fifo_ren = RUN && !fifo_empty && (words issued < W) && a buffer slot is free.
  - Buffer is a current-word shift register plus one prefetch word register.
  - In non-FWFT mode, an issued-but-not-returned read counts as occupying the slot.
  - fifo_ren is never asserted while fifo_empty=1, in any state.
  - words_read increments on every fifo_ren cycle.
- Data capture: fifo_rdata is captured on the ren cycle (pFWFT=1) or the cycle after ren (pFWFT=0).
- Output rules:
  - dout_valid is asserted whenever the current word holds unsent slices and beats remain.
  - dout and dout_valid are stable while dout_valid && !dout_ready.
  - A slice advances only on acceptance. After R slices, the prefetch word (if present) moves to current with no bubble.
- Partial last word: if count is not a multiple of R, only count mod R slices of the final word are sent; the remaining slices are discarded.
- Throughput: with the FIFO non-empty and dout_ready held high, sustain 1 beat per cycle for the whole burst.
- First-beat latency after start (FIFO non-empty): dout_valid rises 2 cycles after start with pFWFT=1, 3 cycles after with pFWFT=0.
- FIFO empty mid-burst: dout_valid drops after buffered beats drain, busy stays 1, and the block resumes when fifo_empty deasserts. There is no timeout.
- Abort (any cycle in RUN):
  - Next cycle: DONE (done pulse), dout_valid=0, fifo_ren=0, buffer flushed.
  - A non-FWFT read issued in the abort cycle is still counted in words_read; its data is discarded.
  - abort in IDLE or DONE has no effect.
- start and abort in the same cycle while IDLE: abort wins, start ignored.

Decomposition:
- Package fifo_unpack_pkg: state encoding (IDLE, RUN, DONE), a ratio constant derived from the parameters, and a slice-index width function.
- One natural sub-module: fifo_unpack_shifter — the current/prefetch word registers plus slice selection by pMSB_FIRST.
- The FSM and counters stay in the top module.

Test Plan:
- FIFO preloaded with 0x1234, 0xABCD; start, count=4, dout_ready=1, pFWFT=0, pMSB_FIRST=1 -> beats 0x12, 0x34, 0xAB, 0xCD on consecutive cycles, first beat 3 cycles after start; done pulse; words_read=2.
- Same data, count=3, pMSB_FIRST=0 -> beats 0x34, 0x12, 0xCD; words_read=2; done asserted 1 cycle after the third accept.
- count=0 -> done one cycle later, fifo_ren never asserted, dout_valid never asserted.
- FIFO holds 1 word, count=6; the 2nd and 3rd words are written 20 cycles later -> after 2 beats dout_valid=0, busy=1, fifo_ren=0 while empty (no FIFO underflow flag); the burst then completes with 6 beats.
- Random dout_ready (50%) over count=1000 with pFWFT=1 -> beat sequence exactly matches the FIFO contents; dout is held stable whenever ready is low.
- abort asserted after 5 beats of count=100; separately, reset asserted mid-burst -> abort gives a done pulse, busy=0, and no further ren; reset returns all outputs to reset values with no done pulse.

Source files
------------

// File: rtl/fifo_unpack_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_unpack_pkg : shared types and helpers for the FIFO stream unpacker
// Revision: 1.0
// ---------------------------------------------------------------------------
package fifo_unpack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned C_DEF_DATA_WIDTH = 16;
    localparam int unsigned C_DEF_OUT_WIDTH  = 8;
    localparam int unsigned C_DEF_RATIO      = C_DEF_DATA_WIDTH / C_DEF_OUT_WIDTH;

    function automatic int unsigned calc_ratio(input int unsigned data_w, input int unsigned out_w);
        return data_w / out_w;
    endfunction

    function automatic int unsigned idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_unpack_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_unpack_shifter : current-word shift register plus one prefetch word
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_unpack_shifter
    import fifo_unpack_pkg::*;
#(
    parameter int pDATA_WIDTH = 16,
    parameter int pOUT_WIDTH  = 8,
    parameter int pMSB_FIRST  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   load,
    input  logic [pDATA_WIDTH-1:0] load_data,
    input  logic                   accept,
    output logic                   cur_valid,
    output logic                   pf_valid,
    output logic [pOUT_WIDTH-1:0]  dout
);

    localparam int unsigned C_RATIO = calc_ratio(pDATA_WIDTH, pOUT_WIDTH);
    localparam int unsigned C_IDX_W = idx_width(C_RATIO);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_RATIO - 1);

    logic [pDATA_WIDTH-1:0] cur_word;
    logic [pDATA_WIDTH-1:0] pf_word;
    logic [pDATA_WIDTH-1:0] cur_shifted;
    logic [C_IDX_W-1:0]     slice_idx;
    logic                   cur_empties;

    generate
        if (pMSB_FIRST != 0) begin : g_msb_first
            assign dout        = cur_word[pDATA_WIDTH-1 -: pOUT_WIDTH];
            assign cur_shifted = cur_word << pOUT_WIDTH;
        end else begin : g_lsb_first
            assign dout        = cur_word[pOUT_WIDTH-1:0];
            assign cur_shifted = cur_word >> pOUT_WIDTH;
        end
    endgenerate

    // Current word frees up when empty or when its final slice is taken.
    assign cur_empties = !cur_valid || (accept && (slice_idx == C_LAST_IDX));

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cur_word  <= '0;
            pf_word   <= '0;
            cur_valid <= 1'b0;
            pf_valid  <= 1'b0;
            slice_idx <= '0;
        end else if (cur_empties) begin
            slice_idx <= '0;
            if (pf_valid) begin
                cur_word  <= pf_word;
                cur_valid <= 1'b1;
                pf_valid  <= load;
                pf_word   <= load ? load_data : '0;
            end else if (load) begin
                cur_word  <= load_data;
                cur_valid <= 1'b1;
            end else begin
                cur_word  <= '0;
                cur_valid <= 1'b0;
            end
        end else begin
            if (accept) begin
                cur_word  <= cur_shifted;
                slice_idx <= slice_idx + 1'b1;
            end
            if (load) begin
                pf_word  <= load_data;
                pf_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_unpacker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_stream_unpacker : drains FIFO words as narrower valid/ready beats
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_stream_unpacker
    import fifo_unpack_pkg::*;
#(
    parameter int pDATA_WIDTH  = 16,
    parameter int pOUT_WIDTH   = 8,
    parameter int pFWFT        = 0,
    parameter int pMSB_FIRST   = 1,
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [pCOUNT_WIDTH-1:0] count,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [pCOUNT_WIDTH-1:0] words_read,
    input  logic                    fifo_empty,
    output logic                    fifo_ren,
    input  logic [pDATA_WIDTH-1:0]  fifo_rdata,
    output logic [pOUT_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    input  logic                    dout_ready
);

    localparam int unsigned C_RATIO = calc_ratio(pDATA_WIDTH, pOUT_WIDTH);

    typedef logic [pCOUNT_WIDTH-1:0] cnt_t;
    typedef logic [pCOUNT_WIDTH:0]   wcnt_t;

    state_t state;
    state_t state_nxt;

    cnt_t       beats_left;
    wcnt_t      words_needed;
    wcnt_t      words_needed_nxt;
    logic       ren_d;
    logic       run;
    logic       start_ok;
    logic       accept;
    logic       last_accept;
    logic       inflight;
    logic       load;
    logic       flush;
    logic       cur_valid;
    logic       pf_valid;
    logic [1:0] occupancy;

    assign run              = (state == ST_RUN);
    assign start_ok         = (state == ST_IDLE) && start && !abort;
    assign words_needed_nxt = (wcnt_t'(count) + wcnt_t'(C_RATIO - 1)) / wcnt_t'(C_RATIO);

    assign dout_valid  = run && cur_valid;
    assign accept      = dout_valid && dout_ready;
    assign last_accept = accept && (beats_left == cnt_t'(1));

    // A non-FWFT read in flight already owns the slot it will land in.
    assign inflight  = (pFWFT != 0) ? 1'b0 : ren_d;
    assign occupancy = 2'(cur_valid) + 2'(pf_valid) + 2'(inflight);
    assign fifo_ren  = run && !fifo_empty && (wcnt_t'(words_read) < words_needed)
                       && (occupancy < 2'd2);

    assign load  = run && ((pFWFT != 0) ? fifo_ren : ren_d);
    assign flush = !run || abort || last_accept;

    fifo_unpack_shifter #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pOUT_WIDTH  (pOUT_WIDTH),
        .pMSB_FIRST  (pMSB_FIRST)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .load      (load),
        .load_data (fifo_rdata),
        .accept    (accept),
        .cur_valid (cur_valid),
        .pf_valid  (pf_valid),
        .dout      (dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            beats_left   <= '0;
            words_needed <= '0;
            words_read   <= '0;
            ren_d        <= 1'b0;
        end else begin
            state <= state_nxt;
            ren_d <= fifo_ren;
            if (start_ok) begin
                beats_left   <= count;
                words_needed <= words_needed_nxt;
                words_read   <= '0;
            end else begin
                if (accept) begin
                    beats_left <= beats_left - 1'b1;
                end
                if (fifo_ren) begin
                    words_read <= words_read + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = (count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort || last_accept) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_unpacker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_stream_unpacker : directed bench, dut0 = normal/MSB-first, dut1 = FWFT/LSB-first
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fifo_stream_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, dready, fifo_clr;
    logic [15:0] count;
    logic        busy [2];
    logic        done [2];
    logic        fren [2];
    logic        dvalid [2];
    logic        fempty [2];
    logic [15:0] wrd [2];
    logic [7:0]  dout [2];
    logic [15:0] rdata0 = '0;
    logic [15:0] rdata1;

    logic [15:0] mem [0:4095];
    logic [11:0] wr_p = '0;
    logic [11:0] rd0 = '0;
    logic [11:0] rd1 = '0;

    int tests = 0;
    int fails = 0;
    int cyc;
    int first_v [2];
    int last_acc [2];
    int done_cyc [2];
    int done_cnt [2];
    int beats [2];
    int exp_total [2];
    bit ren_seen [2];
    bit valid_seen [2];
    bit busy_seen [2];
    bit prev_stall [2];
    logic [7:0] prev_dout [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    fifo_stream_unpacker #(
        .pDATA_WIDTH(16), .pOUT_WIDTH(8), .pFWFT(0), .pMSB_FIRST(1), .pCOUNT_WIDTH(16)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .count(count), .abort(abort),
        .busy(busy[0]), .done(done[0]), .words_read(wrd[0]),
        .fifo_empty(fempty[0]), .fifo_ren(fren[0]), .fifo_rdata(rdata0),
        .dout(dout[0]), .dout_valid(dvalid[0]), .dout_ready(dready)
    );

    fifo_stream_unpacker #(
        .pDATA_WIDTH(16), .pOUT_WIDTH(8), .pFWFT(1), .pMSB_FIRST(0), .pCOUNT_WIDTH(16)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .count(count), .abort(abort),
        .busy(busy[1]), .done(done[1]), .words_read(wrd[1]),
        .fifo_empty(fempty[1]), .fifo_ren(fren[1]), .fifo_rdata(rdata1),
        .dout(dout[1]), .dout_valid(dvalid[1]), .dout_ready(dready)
    );

    // Both FIFO models share one memory; each has its own read pointer.
    assign fempty[0] = (rd0 == wr_p);
    assign fempty[1] = (rd1 == wr_p);
    assign rdata1    = mem[rd1];

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd0 <= wr_p;
            rd1 <= wr_p;
        end else begin
            if (fren[0] && !fempty[0]) begin
                rd0    <= rd0 + 12'd1;
                rdata0 <= mem[rd0];
            end
            if (fren[1] && !fempty[1]) begin
                rd1 <= rd1 + 12'd1;
            end
        end
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d: observed %0h, expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic add_expect(input logic [15:0] w);
        q0.push_back(w[15:8]);
        q0.push_back(w[7:0]);
        q1.push_back(w[7:0]);
        q1.push_back(w[15:8]);
        exp_total[0] += 2;
        exp_total[1] += 2;
    endtask

    task automatic push(input logic [15:0] w, input bit expect_it);
        mem[wr_p] = w;
        wr_p = wr_p + 12'd1;
        if (expect_it) add_expect(w);
    endtask

    task automatic sample();
        logic [7:0] e;
        bit         miss;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                prev_stall[k] = 1'b0;
            end else begin
                if (dvalid[k]) valid_seen[k] = 1'b1;
                if (fren[k]) ren_seen[k] = 1'b1;
                if (busy[k]) busy_seen[k] = 1'b1;
                if (done[k]) begin
                    done_cnt[k]++;
                    if (done_cyc[k] < 0) done_cyc[k] = cyc;
                end
                if (dvalid[k] && first_v[k] < 0) first_v[k] = cyc;
                chk("no_underflow", k, 32'(fren[k] && fempty[k]), 32'd0);
                if (prev_stall[k]) begin
                    chk("hold_valid", k, 32'(dvalid[k]), 32'd1);
                    chk("hold_data", k, 32'(dout[k]), 32'(prev_dout[k]));
                end
                prev_stall[k] = dvalid[k] && !dready && !abort;
                prev_dout[k]  = dout[k];
                if (dvalid[k] && dready) begin
                    beats[k]++;
                    last_acc[k] = cyc;
                    miss = 1'b0;
                    e    = '0;
                    if (k == 0) begin
                        if (q0.size() > 0) e = q0.pop_front(); else miss = 1'b1;
                    end else begin
                        if (q1.size() > 0) e = q1.pop_front(); else miss = 1'b1;
                    end
                    if (miss) chk("beat_overrun", k, 32'(beats[k]), 32'(exp_total[k]));
                    else      chk("beat", k, 32'(dout[k]), 32'(e));
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            first_v[k]    = -1;
            last_acc[k]   = -1;
            done_cyc[k]   = -1;
            done_cnt[k]   = 0;
            beats[k]      = 0;
            exp_total[k]  = 0;
            ren_seen[k]   = 1'b0;
            valid_seen[k] = 1'b0;
            busy_seen[k]  = 1'b0;
            prev_stall[k] = 1'b0;
        end
        q0.delete();
        q1.delete();
        cyc = 0;
    endtask

    task automatic begin_test();
        reset    = 1'b1;
        fifo_clr = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        dready   = 1'b1;
        step();
        step();
        reset    = 1'b0;
        fifo_clr = 1'b0;
        clear_stats();
    endtask

    task automatic pulse_start(input logic [15:0] c);
        count = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_busy"}, k, 32'(busy[k]), 32'd0);
            chk({tag, "_done"}, k, 32'(done[k]), 32'd0);
            chk({tag, "_ren"}, k, 32'(fren[k]), 32'd0);
            chk({tag, "_valid"}, k, 32'(dvalid[k]), 32'd0);
            chk({tag, "_dout"}, k, 32'(dout[k]), 32'd0);
            chk({tag, "_words"}, k, 32'(wrd[k]), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; dready = 1'b1;
        count = '0; fifo_clr = 1'b1;
        clear_stats();
        step();
        step();
        chk_reset_outputs("reset");

        // Full burst, two words
        begin_test();
        push(16'h1234, 1'b1);
        push(16'hABCD, 1'b1);
        pulse_start(16'd4);
        repeat (10) step();
        chk("t1_first_valid", 0, 32'(first_v[0]), 32'd3);
        chk("t1_first_valid", 1, 32'(first_v[1]), 32'd2);
        chk("t1_last_accept", 0, 32'(last_acc[0]), 32'd6);
        chk("t1_last_accept", 1, 32'(last_acc[1]), 32'd5);
        chk("t1_done_cycle", 0, 32'(done_cyc[0]), 32'd7);
        chk("t1_done_cycle", 1, 32'(done_cyc[1]), 32'd6);
        for (int k = 0; k < 2; k++) begin
            chk("t1_beats", k, 32'(beats[k]), 32'd4);
            chk("t1_words_read", k, 32'(wrd[k]), 32'd2);
            chk("t1_done_count", k, 32'(done_cnt[k]), 32'd1);
            chk("t1_busy_end", k, 32'(busy[k]), 32'd0);
        end

        // Partial last word
        begin_test();
        push(16'h1234, 1'b0);
        push(16'hABCD, 1'b0);
        q0 = '{8'h12, 8'h34, 8'hAB};
        q1 = '{8'h34, 8'h12, 8'hCD};
        exp_total[0] = 3;
        exp_total[1] = 3;
        pulse_start(16'd3);
        repeat (10) step();
        chk("t2_last_accept", 0, 32'(last_acc[0]), 32'd5);
        chk("t2_last_accept", 1, 32'(last_acc[1]), 32'd4);
        for (int k = 0; k < 2; k++) begin
            chk("t2_done_after_accept", k, 32'(done_cyc[k]), 32'(last_acc[k] + 1));
            chk("t2_beats", k, 32'(beats[k]), 32'd3);
            chk("t2_words_read", k, 32'(wrd[k]), 32'd2);
        end

        // Zero-length burst with data waiting
        begin_test();
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        pulse_start(16'd0);
        repeat (5) step();
        for (int k = 0; k < 2; k++) begin
            chk("t3_done_cycle", k, 32'(done_cyc[k]), 32'd1);
            chk("t3_done_count", k, 32'(done_cnt[k]), 32'd1);
            chk("t3_ren_seen", k, 32'(ren_seen[k]), 32'd0);
            chk("t3_valid_seen", k, 32'(valid_seen[k]), 32'd0);
            chk("t3_busy_seen", k, 32'(busy_seen[k]), 32'd0);
            chk("t3_words_read", k, 32'(wrd[k]), 32'd0);
        end

        // FIFO runs dry mid-burst
        begin_test();
        push(16'h5566, 1'b1);
        pulse_start(16'd6);
        repeat (9) step();
        for (int k = 0; k < 2; k++) begin
            chk("t4_starved_valid", k, 32'(dvalid[k]), 32'd0);
            chk("t4_starved_busy", k, 32'(busy[k]), 32'd1);
            chk("t4_starved_ren", k, 32'(fren[k]), 32'd0);
            chk("t4_starved_beats", k, 32'(beats[k]), 32'd2);
        end
        for (int i = 0; i < 30 && cyc < 20; i++) step();
        push(16'h7788, 1'b1);
        push(16'h99AA, 1'b1);
        repeat (15) step();
        for (int k = 0; k < 2; k++) begin
            chk("t4_beats", k, 32'(beats[k]), 32'd6);
            chk("t4_done_count", k, 32'(done_cnt[k]), 32'd1);
            chk("t4_words_read", k, 32'(wrd[k]), 32'd3);
        end

        // Long burst under random backpressure
        begin_test();
        for (int i = 0; i < 500; i++) push(16'($urandom), 1'b1);
        pulse_start(16'd1000);
        for (int i = 0; i < 6000 && (done_cnt[0] == 0 || done_cnt[1] == 0); i++) begin
            dready = 1'($urandom_range(0, 1));
            step();
        end
        dready = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t5_beats", k, 32'(beats[k]), 32'd1000);
            chk("t5_done_count", k, 32'(done_cnt[k]), 32'd1);
            chk("t5_words_read", k, 32'(wrd[k]), 32'd500);
        end

        // Abort after dut0 has sent 5 beats
        begin_test();
        for (int i = 0; i < 60; i++) push(16'(i * 16'h0101 + 16'h0F01), 1'b1);
        pulse_start(16'd100);
        repeat (7) step();
        dready = 1'b0;
        abort  = 1'b1;
        step();
        abort  = 1'b0;
        dready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ren_seen[k]   = 1'b0;
            valid_seen[k] = 1'b0;
        end
        repeat (5) step();
        chk("t6_beats", 0, 32'(beats[0]), 32'd5);
        chk("t6_beats", 1, 32'(beats[1]), 32'd6);
        chk("t6_words_read", 0, 32'(wrd[0]), 32'd4);
        chk("t6_words_read", 1, 32'(wrd[1]), 32'd5);
        for (int k = 0; k < 2; k++) begin
            chk("t6_done_cycle", k, 32'(done_cyc[k]), 32'd9);
            chk("t6_done_count", k, 32'(done_cnt[k]), 32'd1);
            chk("t6_ren_after", k, 32'(ren_seen[k]), 32'd0);
            chk("t6_valid_after", k, 32'(valid_seen[k]), 32'd0);
            chk("t6_busy_end", k, 32'(busy[k]), 32'd0);
        end

        // Reset in the middle of a burst
        begin_test();
        for (int i = 0; i < 60; i++) push(16'(i * 16'h0203 + 16'h1100), 1'b1);
        pulse_start(16'd100);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_outputs("t7_after_reset");
        for (int k = 0; k < 2; k++) begin
            busy_seen[k]  = 1'b0;
            valid_seen[k] = 1'b0;
        end
        repeat (5) step();
        for (int k = 0; k < 2; k++) begin
            chk("t7_done_count", k, 32'(done_cnt[k]), 32'd0);
            chk("t7_busy_seen", k, 32'(busy_seen[k]), 32'd0);
            chk("t7_valid_seen", k, 32'(valid_seen[k]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
